// File: rtl/uart_tx_if.sv
// uart_tx_if: character handshake between the UART front end and the transmitter.
// The master presents tx_data/tx_valid; the transmitter answers with tx_ready.
interface uart_tx_if;
  logic [8:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 5-9 bit UART transmitter, LSB first, optional parity, 1/2 stop bits.
// Define TX_BREAK_EN to add a tx_break input that holds the idle line low.
module uart_tx #(
  parameter logic IDLE_LEVEL    = 1'b1,
  parameter int   TICKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_en,
  input  logic [1:0]  parity,
  input  logic [2:0]  data_bits,
  input  logic        stop_bit,
  input  logic [15:0] tx_divisor,
`ifdef TX_BREAK_EN
  input  logic        tx_break,
`endif
  uart_tx_if.slave    bus,
  output logic        tx,
  output logic        tx_busy,
  output logic        tx_done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int TW =
    (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TICKS_PER_BIT - 1);

  logic [2:0]    state;
  logic [15:0]   div_cnt;
  logic [TW-1:0] tick_cnt;
  logic [8:0]    shift;
  logic [3:0]    nbits;
  logic [3:0]    bit_cnt;
  logic          par_en;
  logic          par_val;
  logic          stop2;
  logic          stop_cnt;

  logic [15:0]   sub_div;
  logic [15:0]   reload;
  logic          sub_tick;
  logic          bit_end;
  logic          accept;
  logic          brk;
  logic [3:0]    n_cfg;
  logic [8:0]    mask;
  logic [8:0]    masked;

`ifdef TX_BREAK_EN
  assign brk = tx_break;
`else
  assign brk = 1'b0;
`endif

  always_comb begin
    sub_div  = tx_divisor >> 4;
    reload   = (sub_div == 16'd0) ? 16'd0 : sub_div - 16'd1;
    sub_tick = (div_cnt == 16'd0);
    bit_end  = (state != IDLE) && sub_tick && (tick_cnt == TLAST);
    accept   = bus.tx_valid && bus.tx_ready;
    n_cfg    = 4'd8;
    unique case (data_bits)
      3'd0:    n_cfg = 4'd5;
      3'd1:    n_cfg = 4'd6;
      3'd2:    n_cfg = 4'd7;
      3'd4:    n_cfg = 4'd9;
      default: n_cfg = 4'd8;
    endcase
    mask   = 9'h1FF >> (4'd9 - n_cfg);
    masked = bus.tx_data & mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      div_cnt      <= '0;
      tick_cnt     <= '0;
      shift        <= '0;
      nbits        <= '0;
      bit_cnt      <= '0;
      par_en       <= 1'b0;
      par_val      <= 1'b0;
      stop2        <= 1'b0;
      stop_cnt     <= 1'b0;
      tx           <= IDLE_LEVEL;
      bus.tx_ready <= 1'b0;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
    end else begin
      tx_done      <= 1'b0;
      bus.tx_ready <= (state == IDLE) && tx_en && !accept && !brk;

      if (state != IDLE) begin
        if (sub_tick) begin
          div_cnt  <= reload;
          tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
        end else begin
          div_cnt  <= div_cnt - 16'd1;
        end
      end

      unique case (state)
        IDLE: begin
          tx <= brk ? 1'b0 : IDLE_LEVEL;
          if (accept) begin
            // Counters restart here so the start bit gets its full length
            state    <= START;
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
            div_cnt  <= reload;
            tick_cnt <= '0;
            shift    <= masked;
            nbits    <= n_cfg;
            bit_cnt  <= '0;
            par_en   <= (parity == 2'b01) || (parity == 2'b10);
            par_val  <= (^masked) ^ (parity == 2'b01);
            stop2    <= stop_bit;
            stop_cnt <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            tx    <= shift[0];
            shift <= shift >> 1;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == nbits - 4'd1) begin
              if (par_en) begin
                state <= PARITY;
                tx    <= par_val;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              tx      <= shift[0];
              shift   <= shift >> 1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (stop2 && !stop_cnt) begin
              stop_cnt <= 1'b1;
            end else begin
              state   <= IDLE;
              div_cnt <= '0;
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          tx      <= IDLE_LEVEL;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed and random frames against a bit-list reference model.
// Every cycle of each frame is compared with the expected line level.
module tb_uart_tx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        tx_en = 1'b0;
  logic [1:0]  parity = 2'd0;
  logic [2:0]  data_bits = 3'd3;
  logic        stop_bit = 1'b0;
  logic [15:0] tx_divisor = 16'd64;
  logic        tx;
  logic        tx_busy;
  logic        tx_done;
`ifdef TX_BREAK_EN
  logic        tx_break = 1'b0;
`endif

  uart_tx_if bus ();

  uart_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_en      (tx_en),
    .parity     (parity),
    .data_bits  (data_bits),
    .stop_bit   (stop_bit),
    .tx_divisor (tx_divisor),
`ifdef TX_BREAK_EN
    .tx_break   (tx_break),
`endif
    .bus        (bus),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  int bit_len;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line levels, one entry per bit, from the frame rules
  function automatic void build(logic [8:0] d, logic [1:0] p,
                                logic [2:0] db, logic s);
    int n;
    int ones;
    int sd;
    n = (db <= 3'd4) ? int'(db) + 5 : 8;
    ones = 0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (p == 2'b01) exp_q.push_back((ones % 2) == 0);
    if (p == 2'b10) exp_q.push_back((ones % 2) == 1);
    exp_q.push_back(1'b1);
    if (s) exp_q.push_back(1'b1);
    sd = int'(tx_divisor) / 16;
    bit_len = 16 * ((sd == 0) ? 1 : sd);
  endfunction

  task automatic send(logic [8:0] d, output int waited);
    logic rdy;
    bit acc;
    acc = 1'b0;
    waited = 0;
    bus.tx_data = d;
    bus.tx_valid = 1'b1;
    while (!acc && waited < 400) begin
      rdy = bus.tx_ready;
      @(posedge clk);
      #1;
      waited++;
      if (rdy) acc = 1'b1;
      else begin
        check("idle_tx", tx, 1);
        check("idle_done", tx_done, 0);
      end
    end
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic frame(logic [8:0] d, logic [1:0] p, logic [2:0] db,
                       logic s, bit scramble, bit drop_en,
                       int rst_at, output int waited);
    int f;
    parity = p;
    data_bits = db;
    stop_bit = s;
    build(d, p, db, s);
    f = exp_q.size();
    send(d, waited);
    if (!drop_en) bus.tx_valid = 1'b0;
    for (int k = 0; k <= f * bit_len; k++) begin
      if (k == rst_at) begin
        rst_n = 1'b0;
        #2;
        check("rst_tx", tx, 1);
        check("rst_ready", bus.tx_ready, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        return;
      end
      if (k < f * bit_len) begin
        check("frame_tx", tx, exp_q[k / bit_len]);
        check("frame_done", tx_done, 0);
        check("frame_ready", bus.tx_ready, 0);
        check("frame_busy", tx_busy, 1);
      end else begin
        check("end_done", tx_done, 1);
        check("end_tx", tx, 1);
        check("end_busy", tx_busy, 0);
        check("end_ready", bus.tx_ready, 0);
      end
      if (scramble && k == 1) begin
        bus.tx_data = 9'($urandom);
        parity = 2'($urandom);
        data_bits = 3'($urandom);
        stop_bit = 1'($urandom);
      end
      if (drop_en && k == bit_len / 2) tx_en = 1'b0;
      if (k < f * bit_len) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    int w;
    bus.tx_valid = 1'b0;
    bus.tx_data = 9'd0;
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_tx", tx, 1);
    check("reset_ready", bus.tx_ready, 0);
    check("reset_busy", tx_busy, 0);
    check("reset_done", tx_done, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tx_en = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", bus.tx_ready, 1);

    tx_divisor = 16'd64;
    frame(9'h0A5, 2'b00, 3'd3, 1'b0, 1'b0, 1'b0, -1, w);
    frame(9'h1C1, 2'b10, 3'd2, 1'b0, 1'b0, 1'b0, -1, w);
    frame(9'h015, 2'b01, 3'd0, 1'b1, 1'b0, 1'b0, -1, w);
    frame(9'h1FF, 2'b11, 3'd4, 1'b0, 1'b0, 1'b0, -1, w);
    frame(9'h000, 2'b11, 3'd4, 1'b0, 1'b0, 1'b0, -1, w);
    check("b2b_gap_le2", (w <= 2), 1);

    frame(9'h0A5, 2'b00, 3'd3, 1'b0, 1'b0, 1'b0, 3 * 64 + 5, w);
    repeat (20) begin
      @(posedge clk);
      #1;
      check("post_rst_done", tx_done, 0);
      check("post_rst_tx", tx, 1);
    end
    check("post_rst_ready", bus.tx_ready, 1);

    frame(9'h03C, 2'b00, 3'd3, 1'b0, 1'b0, 1'b1, -1, w);
    repeat (50) begin
      @(posedge clk);
      #1;
      check("en_low_ready", bus.tx_ready, 0);
      check("en_low_busy", tx_busy, 0);
      check("en_low_tx", tx, 1);
    end
    tx_en = 1'b1;
    frame(9'h03C, 2'b00, 3'd3, 1'b0, 1'b0, 1'b0, -1, w);

`ifdef TX_BREAK_EN
    tx_break = 1'b1;
    repeat (1000) begin
      @(posedge clk);
      #1;
      check("break_tx", tx, 0);
      check("break_ready", bus.tx_ready, 0);
    end
    tx_break = 1'b0;
    @(posedge clk);
    #1;
    check("break_release_tx", tx, 1);
    @(posedge clk);
    #1;
    check("break_release_ready", bus.tx_ready, 1);
`endif

    for (int r = 0; r < 10; r++) begin
      tx_divisor = 16'($urandom_range(0, 80));
      frame(9'($urandom), 2'($urandom), 3'($urandom), 1'($urandom),
            1'b1, 1'b0, -1, w);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
